// File: rtl/jellyvl_etherneco_packet_tx.sv
// jellyvl_etherneco_packet_tx: ring-bus frame transmitter (preamble, header, payload, CRC-32 FCS); ports: clk/reset, tx_* command, s_payload_* source, m_tx_* byte stream
module jellyvl_etherneco_packet_tx #(
  parameter int PREAMBLE_BYTES = 8,
  parameter bit FCS_ENABLE     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [7:0]  tx_node,
  input  logic [7:0]  tx_type,
  input  logic [15:0] tx_length,
  output logic        tx_busy,
  output logic        tx_done,
  input  logic [7:0]  s_payload_data,
  input  logic        s_payload_valid,
  output logic        s_payload_ready,
  output logic        m_tx_first,
  output logic        m_tx_last,
  output logic [7:0]  m_tx_data,
  output logic        m_tx_valid,
  input  logic        m_tx_ready
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS} state_t;
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  state_t      state, state_next, state_end;
  logic [15:0] cnt, cnt_next, len;
  logic [7:0]  node, kind, byte_data;
  logic [31:0] crc, crc_byte, crc_out;
  logic        load, accept, avail, step, end_of, byte_last;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    load            = !m_tx_valid | m_tx_ready;
    accept          = tx_start & !tx_busy;
    avail           = (state == PAYLOAD) ? s_payload_valid : (state != IDLE);
    step            = load & avail;
    s_payload_ready = (state == PAYLOAD) & load;
    crc_out         = ~crc;
    byte_data       = 8'h00;
    byte_last       = 1'b0;
    end_of          = 1'b0;
    state_end       = IDLE;
    case (state)
      PREAMBLE: begin
        byte_data = (cnt == PRE_LAST) ? 8'hD5 : 8'h55;
        end_of    = cnt == PRE_LAST;
        state_end = HEADER;
      end
      HEADER: begin
        byte_data = cnt[1:0] == 2'd0 ? node : cnt[1:0] == 2'd1 ? kind : cnt[1:0] == 2'd2 ? len[7:0] : len[15:8];
        end_of    = cnt[1:0] == 2'd3;
        state_end = PAYLOAD;
      end
      PAYLOAD: begin
        byte_data = s_payload_data;
        end_of    = cnt == len;
        byte_last = end_of & !FCS_ENABLE;
        state_end = FCS_ENABLE ? FCS : IDLE;
      end
      FCS: begin
        byte_data = crc_out[{cnt[1:0], 3'b000} +: 8];
        end_of    = cnt[1:0] == 2'd3;
        byte_last = end_of;
        state_end = IDLE;
      end
      default: ;
    endcase
    crc_byte   = crc_step(crc, byte_data);
    // the first preamble byte is loaded directly at accept, so the counter resumes at 1
    state_next = accept ? PREAMBLE : (step & end_of) ? state_end : state;
    cnt_next   = accept ? 16'd1 : !step ? cnt : end_of ? 16'd0 : cnt + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      node       <= '0;
      kind       <= '0;
      len        <= '0;
      crc        <= '1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      m_tx_first <= 1'b0;
      m_tx_last  <= 1'b0;
      m_tx_data  <= '0;
      m_tx_valid <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      tx_done <= 1'b0;
      if (accept) begin
        node       <= tx_node;
        kind       <= tx_type;
        len        <= tx_length;
        crc        <= '1;
        tx_busy    <= 1'b1;
        m_tx_first <= 1'b1;
        m_tx_last  <= 1'b0;
        m_tx_data  <= 8'h55;
        m_tx_valid <= 1'b1;
      end else if (load) begin
        m_tx_valid <= step;
        if (step) begin
          m_tx_first <= 1'b0;
          m_tx_last  <= byte_last;
          m_tx_data  <= byte_data;
        end
        if (step & (state == HEADER | state == PAYLOAD)) crc <= crc_byte;
      end
      if (m_tx_valid & m_tx_ready & m_tx_last) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jellyvl_etherneco_packet_tx.sv
// tb_jellyvl_etherneco_packet_tx: scoreboard bench for the frame transmitter
module tb_jellyvl_etherneco_packet_tx;
  logic        clk = 1'b0, reset;
  logic        tx_start, tx_busy, tx_done;
  logic [7:0]  tx_node, tx_type;
  logic [15:0] tx_length;
  logic [7:0]  s_payload_data;
  logic        s_payload_valid, s_payload_ready;
  logic        m_tx_first, m_tx_last, m_tx_valid, m_tx_ready;
  logic [7:0]  m_tx_data;
  logic        n_start, n_busy, n_done, n_pvalid, n_pready, n_first, n_last, n_valid, n_ready;
  logic [7:0]  n_node, n_type, n_pdata, n_data;
  logic [15:0] n_length;
  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0, done_cyc = 0, pay_cnt = 0, busy_cnt = 0, bubbles = 0;
  int rmode = 0, uf_at = -1, uf_left = 0;
  logic        pstall = 1'b0, n_hs = 1'b0;
  logic [10:0] pout = '0;
  logic [7:0]  n_idx = 8'h00;
  logic [9:0]  exp_q[$], n_q[$], frm[$];
  logic [7:0]  pay_q[$], pl[$], rx[$];

  always #5 clk = ~clk;

  jellyvl_etherneco_packet_tx u_dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_node(tx_node), .tx_type(tx_type),
    .tx_length(tx_length), .tx_busy(tx_busy), .tx_done(tx_done),
    .s_payload_data(s_payload_data), .s_payload_valid(s_payload_valid), .s_payload_ready(s_payload_ready),
    .m_tx_first(m_tx_first), .m_tx_last(m_tx_last), .m_tx_data(m_tx_data),
    .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready)
  );

  jellyvl_etherneco_packet_tx #(.PREAMBLE_BYTES(4), .FCS_ENABLE(1'b0)) u_nofcs (
    .clk(clk), .reset(reset), .tx_start(n_start), .tx_node(n_node), .tx_type(n_type),
    .tx_length(n_length), .tx_busy(n_busy), .tx_done(n_done),
    .s_payload_data(n_pdata), .s_payload_valid(n_pvalid), .s_payload_ready(n_pready),
    .m_tx_first(n_first), .m_tx_last(n_last), .m_tx_data(n_data),
    .m_tx_valid(n_valid), .m_tx_ready(n_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction

  function automatic logic [31:0] residue();
    logic [31:0] c = '1;
    for (int i = 8; i < rx.size(); i++) c = crc_bits(c, rx[i]);
    return c;
  endfunction

  task automatic build(input logic [7:0] nd, input logic [7:0] ty, input logic [15:0] ln,
                       input logic [7:0] base, input bit fcs, input int pb);
    logic [31:0] c, f;
    logic [7:0]  b;
    logic [7:0]  h[4];
    frm.delete();
    pl.delete();
    c = '1;
    h[0] = nd; h[1] = ty; h[2] = ln[7:0]; h[3] = ln[15:8];
    for (int i = 0; i < pb; i++) frm.push_back({i == 0, 1'b0, (i == pb - 1) ? 8'hD5 : 8'h55});
    for (int i = 0; i < 4; i++) begin
      frm.push_back({2'b00, h[i]});
      c = crc_bits(c, h[i]);
    end
    for (int i = 0; i <= int'(ln); i++) begin
      b = base + 8'(i);
      pl.push_back(b);
      frm.push_back({1'b0, !fcs && i == int'(ln), b});
      c = crc_bits(c, b);
    end
    f = ~c;
    if (fcs) for (int i = 0; i < 4; i++) frm.push_back({1'b0, i == 3, f[8*i +: 8]});
  endtask

  task automatic start(input logic [7:0] nd, input logic [7:0] ty, input logic [15:0] ln, input logic [7:0] base);
    build(nd, ty, ln, base, 1'b1, 8);
    exp_q = {exp_q, frm};
    pay_q = {pay_q, pl};
    tx_node = nd; tx_type = ty; tx_length = ln; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; tx_node = 8'hEE; tx_type = 8'hEE; tx_length = 16'h0BAD;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!tx_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_done, 1);
  endtask

  // source, sink and stall monitor for the main instance
  initial forever begin
    @(negedge clk);
    cyc++;
    m_tx_ready = (rmode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
    if (uf_left > 0) uf_left--;
    s_payload_valid = pay_q.size() > 0 && uf_left == 0;
    s_payload_data  = pay_q.size() > 0 ? pay_q[0] : 8'h00;
    #1;
    if (!reset) begin
      if (tx_busy) busy_cnt++;
      if (tx_busy && !m_tx_valid) bubbles++;
      if (tx_done) done_cyc = cyc;
      if (pstall) check("stall_hold", {m_tx_valid, m_tx_first, m_tx_last, m_tx_data}, pout);
      if (m_tx_valid && !m_tx_ready) check("stall_pready", s_payload_ready, 0);
      pstall = m_tx_valid && !m_tx_ready;
      pout   = {m_tx_valid, m_tx_first, m_tx_last, m_tx_data};
      if (s_payload_valid && s_payload_ready) begin
        void'(pay_q.pop_front());
        pay_cnt++;
        if (pay_cnt == uf_at) uf_left = 6;
      end
      if (m_tx_valid && m_tx_ready) begin
        rx.push_back(m_tx_data);
        if (m_tx_last) last_cyc = cyc;
        if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
        else check("frame_byte", {m_tx_first, m_tx_last, m_tx_data}, exp_q.pop_front());
      end
    end else pstall = 1'b0;
  end

  // source and sink for the FCS-less instance
  initial forever begin
    @(negedge clk);
    if (n_hs) n_idx = n_idx + 8'd1;
    n_pdata = n_idx;
    #1;
    n_hs = n_pready && n_pvalid && !reset;
    if (!reset && n_valid) begin
      if (n_q.size() == 0) check("nofcs_extra", n_q.size(), 1);
      else check("nofcs_byte", {n_first, n_last, n_data}, n_q.pop_front());
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; tx_start = 1'b0; tx_node = '0; tx_type = '0; tx_length = '0;
    n_start = 1'b0; n_node = '0; n_type = '0; n_length = '0; n_pvalid = 1'b1; n_ready = 1'b1; n_pdata = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_out", {m_tx_valid, m_tx_first, m_tx_last, m_tx_data, tx_busy, tx_done, s_payload_ready}, 0);
    reset = 1'b0;
    @(negedge clk);
    rx.delete(); bubbles = 0;
    start(8'h01, 8'h10, 16'd3, 8'hA0);
    wait_done("basic_done");
    #2;
    check("basic_len", rx.size(), 20);
    check("basic_residue", residue(), 32'hDEBB20E3);
    check("done_latency", done_cyc - last_cyc, 1);
    check("basic_no_bubble", bubbles, 0);
    check("basic_drain", exp_q.size(), 0);
    @(negedge clk);
    check("done_pulse", tx_done, 0);
    rx.delete(); busy_cnt = 0;
    start(8'h22, 8'h33, 16'd0, 8'h5A);
    wait_done("min_done");
    #2;
    check("min_len", rx.size(), 17);
    check("min_busy", busy_cnt, 17);
    check("min_drain", exp_q.size(), 0);
    @(negedge clk);
    rmode = 1; rx.delete();
    start(8'h01, 8'h10, 16'd3, 8'hA0);
    wait_done("bp_done");
    #2;
    check("bp_residue", residue(), 32'hDEBB20E3);
    check("bp_drain", exp_q.size(), 0);
    rmode = 0;
    @(negedge clk);
    uf_at = 2; pay_cnt = 0; bubbles = 0;
    start(8'h44, 8'h55, 16'd7, 8'hC0);
    wait_done("uf_done");
    #2;
    check("uf_bubble", bubbles > 0, 1);
    check("uf_drain", exp_q.size(), 0);
    uf_at = -1;
    @(negedge clk);
    start(8'h66, 8'h77, 16'd5, 8'h10);
    repeat (4) @(negedge clk);
    tx_node = 8'h99; tx_length = 16'd1; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("coll_done");
    start(8'h88, 8'h99, 16'd2, 8'hE0);
    wait_done("b2b_done");
    #2;
    check("b2b_drain", exp_q.size(), 0);
    @(negedge clk);
    build(8'h12, 8'h34, 16'd2, n_idx, 1'b0, 4);
    n_q = frm;
    n_node = 8'h12; n_type = 8'h34; n_length = 16'd2; n_start = 1'b1;
    @(negedge clk);
    n_start = 1'b0;
    n = 0;
    while (!n_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("nofcs_done", n_done, 1);
    #2;
    check("nofcs_drain", n_q.size(), 0);
    @(negedge clk);
    pay_cnt = 0;
    start(8'hAB, 8'hCD, 16'd7, 8'h30);
    n = 0;
    while (pay_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_payload", pay_cnt >= 2, 1);
    reset = 1'b1;
    exp_q.delete();
    pay_q.delete();
    @(negedge clk);
    #2;
    check("reset_mid", {m_tx_valid, m_tx_first, m_tx_last, m_tx_data, tx_busy, tx_done, s_payload_ready}, 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("reset_no_done", {tx_done, m_tx_last, m_tx_valid}, 0);
    end
    @(negedge clk);
    rx.delete();
    start(8'h01, 8'h10, 16'd3, 8'hA0);
    wait_done("after_reset_done");
    #2;
    check("after_reset_residue", residue(), 32'hDEBB20E3);
    check("after_reset_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
